// File: rtl/alu_pkg.sv
// Shared definitions for the integer ALU and its issue stage.
package alu_pkg;

  // ALU op code is {funct7[5], funct3} of the RV32I OP / OP-IMM encodings.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } stage_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit integer ALU fed by alu_issue_stage.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] x
);

  // Result select; shifts use only the low five bits of b.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    x = '0;
    case (op)
      ALU_ADD:  x = a + b;
      ALU_SUB:  x = a - b;
      ALU_SLL:  x = a << b[4:0];
      ALU_SRL:  x = a >> b[4:0];
      ALU_SRA:  x = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  x = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: x = {31'b0, a < b};
      ALU_XOR:  x = a ^ b;
      ALU_OR:   x = a | b;
      ALU_AND:  x = a & b;
      default:  x = '0;
    endcase
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Register file: two asynchronous read ports, one synchronous write port,
// x0 reads as zero, whole array cleared by reset.
module regfile_2r1w #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs_q [NREGS];

  // Write port; the architectural state must read zero after any reset.
  // NOTE: state updates use <= so every flop samples pre-edge values; the array is
  // reset explicitly because it is built from flops and a reset must clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/alu_issue_stage.sv
// Decode / register-read stage in front of the combinational ALU. Issues one
// RV32I OP/OP-IMM instruction per cycle, forwards the in-flight result, and
// retires results into the register file two cycles after accept.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_x,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            err,
  input  logic            err_clr
);

  stage_state_e    state_q, state_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] alu_a_q, alu_a_d;
  logic [XLEN-1:0] alu_b_q, alu_b_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic            ex_valid_q, ex_valid_d;
  logic [4:0]      ex_rd_q, ex_rd_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  // Instruction fields.
  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];
  assign imm    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};

  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            accept;

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2),
    .we     (ex_valid_q),
    .waddr  (ex_rd_q),
    .wdata  (alu_x)
  );

  // The instruction in EX has not reached the register file yet, so its result
  // is bypassed; ex_rd of zero never forwards, keeping x0 reads at zero.
  assign rs1_val = (ex_valid_q && (ex_rd_q != 5'd0) && (rs1 == ex_rd_q)) ? alu_x : rf_rd1;
  assign rs2_val = (ex_valid_q && (ex_rd_q != 5'd0) && (rs2 == ex_rd_q)) ? alu_x : rf_rd2;

  assign in_ready = (state_q == RUN) && !rst;
  assign accept   = in_valid && in_ready;

  logic            dec_legal;
  logic [XLEN-1:0] dec_a, dec_b;
  logic [3:0]      dec_op;

  // Decode operands, op code and legality of the offered instruction.
  always_comb begin
    dec_legal = 1'b0;
    dec_a     = rs1_val;
    dec_b     = rs2_val;
    dec_op    = {funct7[5], funct3};
    case (opcode)
      OPC_OP: begin
        dec_legal = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_OPIMM: begin
        dec_b  = imm;
        dec_op = {(funct3 == 3'b101) && in_instr[30], funct3};
        case (funct3)
          3'b001:  dec_legal = (funct7 == 7'b0000000);
          3'b101:  dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          default: dec_legal = 1'b1;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Next state: RUN/HALT control, EX issue, and writeback capture of alu_x.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    ex_valid_d = 1'b0;
    ex_rd_d    = ex_rd_q;
    wb_valid_d = ex_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;

    if (ex_valid_q) begin
      wb_rd_d   = ex_rd_q;
      wb_data_d = alu_x;
    end

    case (state_q)
      RUN: begin
        if (accept) begin
          if (dec_legal) begin
            alu_a_d    = dec_a;
            alu_b_d    = dec_b;
            alu_op_d   = dec_op;
            ex_valid_d = 1'b1;
            ex_rd_d    = rd;
          end else begin
            state_d = HALT;
            err_d   = 1'b1;
          end
        end
      end
      HALT: begin
        if (err_clr) begin
          state_d = RUN;
          err_d   = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Pipeline and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      err_q      <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= 4'b0000;
      ex_valid_q <= 1'b0;
      ex_rd_q    <= 5'd0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign err      = err_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage driving the real ALU; expected values are
// hand-computed from the RV32I semantics of each instruction word.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] alu_a, alu_b, alu_x;
  logic [3:0]  alu_op;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;
  logic        err_clr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_x    (alu_x),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .err      (err),
    .err_clr  (err_clr)
  );

  alu u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .x  (alu_x)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_wb(input string tag, input logic [4:0] rd, input logic [31:0] data);
    check({tag, "_valid"}, {31'b0, wb_valid}, 32'd1);
    check({tag, "_rd"},    {27'b0, wb_rd},    {27'b0, rd});
    check({tag, "_data"},  wb_data,           data);
  endtask

  // Drive one cycle of input, then land 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic [31:0] ins);
    in_valid = v;
    in_instr = ins;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_instr = 32'h0;
    err_clr  = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset state.
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_alu_a",    alu_a, 32'h0);
    check("rst_alu_b",    alu_b, 32'h0);
    check("rst_alu_op",   {28'b0, alu_op}, 32'h0);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_wb_data",  wb_data, 32'h0);
    check("rst_err",      {31'b0, err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("run_in_ready", {31'b0, in_ready}, 32'd1);

    // Back-to-back with forwarding of x2 into add x3.
    cyc(1'b1, 32'h02000093);                 // addi x1,x0,32
    check("ex1_alu_a",  alu_a, 32'h0);
    check("ex1_alu_b",  alu_b, 32'h20);
    check("ex1_alu_op", {28'b0, alu_op}, 32'h0);
    check("ex1_nowb",   {31'b0, wb_valid}, 32'd0);
    cyc(1'b1, 32'h00200113);                 // addi x2,x0,2
    check_wb("wb_x1", 5'd1, 32'h20);
    cyc(1'b1, 32'h002081B3);                 // add x3,x1,x2
    check_wb("wb_x2", 5'd2, 32'h2);
    check("fwd_alu_a", alu_a, 32'h20);
    check("fwd_alu_b", alu_b, 32'h2);
    cyc(1'b0, 32'h0);
    check_wb("wb_x3", 5'd3, 32'h22);
    cyc(1'b0, 32'h0);
    check("idle_wb", {31'b0, wb_valid}, 32'd0);
    check("idle_hold_a", alu_a, 32'h20);

    // Op coverage.
    cyc(1'b1, 32'h40208233);                 // sub x4,x1,x2
    check("sub_op", {28'b0, alu_op}, 32'h8);
    cyc(1'b1, 32'h002092B3);                 // sll x5,x1,x2
    check_wb("wb_x4", 5'd4, 32'h1E);
    cyc(1'b1, 32'hFFF00313);                 // addi x6,x0,-1
    check_wb("wb_x5", 5'd5, 32'h80);
    cyc(1'b1, 32'h40435393);                 // srai x7,x6,4
    check_wb("wb_x6", 5'd6, 32'hFFFFFFFF);
    check("srai_op", {28'b0, alu_op}, 32'hD);
    check("srai_a",  alu_a, 32'hFFFFFFFF);
    check("srai_b",  alu_b, 32'h404);
    cyc(1'b1, 32'h0060B433);                 // sltu x8,x1,x6
    check_wb("wb_x7", 5'd7, 32'hFFFFFFFF);
    cyc(1'b0, 32'h0);
    check_wb("wb_x8", 5'd8, 32'h1);

    // x0 handling: pulse with rd 0, then x0 still reads zero (no forwarding).
    cyc(1'b1, 32'h00500013);                 // addi x0,x0,5
    cyc(1'b1, 32'h000004B3);                 // add x9,x0,x0
    check_wb("wb_x0", 5'd0, 32'h5);
    check("x0_alu_a", alu_a, 32'h0);
    check("x0_alu_b", alu_b, 32'h0);
    cyc(1'b0, 32'h0);
    check_wb("wb_x9", 5'd9, 32'h0);
    cyc(1'b0, 32'h0);

    // Illegal instruction after a legal one.
    cyc(1'b1, 32'h00700513);                 // addi x10,x0,7
    cyc(1'b1, 32'h00000000);                 // illegal
    check_wb("wb_x10", 5'd10, 32'h7);
    check("ill_err",      {31'b0, err}, 32'd1);
    check("ill_in_ready", {31'b0, in_ready}, 32'd0);
    cyc(1'b1, 32'h00100593);                 // addi x11 offered while halted
    check("ill_nowb",     {31'b0, wb_valid}, 32'd0);
    check("halt_err",     {31'b0, err}, 32'd1);
    cyc(1'b1, 32'h00100593);
    check("halt_nowb",     {31'b0, wb_valid}, 32'd0);
    check("halt_in_ready", {31'b0, in_ready}, 32'd0);
    err_clr = 1'b1;
    cyc(1'b0, 32'h0);
    err_clr = 1'b0;
    check("clr_err",      {31'b0, err}, 32'd0);
    check("clr_in_ready", {31'b0, in_ready}, 32'd1);
    cyc(1'b0, 32'h0);
    check("clr_nowb", {31'b0, wb_valid}, 32'd0);

    // Reset one cycle after an accept: no writeback, state and registers cleared.
    cyc(1'b1, 32'h02000093);                 // addi x1,x0,32
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_alu_a",    alu_a, 32'h0);
    check("mid_alu_b",    alu_b, 32'h0);
    check("mid_in_ready", {31'b0, in_ready}, 32'd0);
    check("mid_wb_data",  wb_data, 32'h0);
    check("mid_wb_rd",    {27'b0, wb_rd}, 32'h0);
    @(posedge clk);
    #1;
    check("mid_nowb", {31'b0, wb_valid}, 32'd0);
    rst = 1'b0;
    #1;
    cyc(1'b1, 32'h000080B3);                 // add x1,x1,x0
    cyc(1'b0, 32'h0);
    check_wb("post_rst_x1", 5'd1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
